// File: rtl/uart_rx_buffered.sv
// ============================================================================
// Module  : uart_rx_buffered
// Brief   : 8N1 UART receiver feeding a show-ahead FIFO with valid/ready read,
//           stop-bit checking, false-start rejection and sticky overrun.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_buffered #(
   parameter int CLK_FREQ_MHZ = 100,
   parameter int BAUD_RATE    = 115200,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              rxd_i,
   output logic                              rvalid_o,
   input  logic                              rready_i,
   output logic [7:0]                        rdata_o,
   output logic                              frame_err_o,
   output logic                              overrun_o,
   input  logic                              clr_i,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   count_o
);

   localparam int c_wait_count = CLK_FREQ_MHZ * 1000000 / BAUD_RATE;
   localparam int c_tmr_w      = $clog2(c_wait_count);
   localparam int c_ptr_w      = $clog2(FIFO_DEPTH);
   localparam int c_cnt_w      = $clog2(FIFO_DEPTH + 1);

   localparam logic [c_tmr_w-1:0] c_half_wait = c_tmr_w'(c_wait_count / 2 - 1);
   localparam logic [c_tmr_w-1:0] c_full_wait = c_tmr_w'(c_wait_count - 1);
   localparam logic [c_cnt_w-1:0] c_depth     = c_cnt_w'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_t;

   // Both stages reset high so leaving reset never looks like a start bit.
   logic r_rxd_meta;
   logic r_rxd;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rxd_meta <= 1'b1;
         r_rxd      <= 1'b1;
      end else begin
         r_rxd_meta <= rxd_i;
         r_rxd      <= r_rxd_meta;
      end
   end

   state_t               r_state;
   logic [c_tmr_w-1:0]   r_tmr;
   logic [2:0]           r_bit_idx;
   logic [7:0]           r_shift;
   logic                 r_frame_err;
   logic                 r_overrun;

   logic [7:0]           r_mem [FIFO_DEPTH];
   logic [c_ptr_w-1:0]   r_wr_ptr;
   logic [c_ptr_w-1:0]   r_rd_ptr;
   logic [c_cnt_w-1:0]   r_count;
   logic                 r_rvalid;

   logic                 w_tmr_zero;
   logic                 w_stop_ok;
   logic                 w_full;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_ovr_evt;
   logic [c_cnt_w-1:0]   w_count_nxt;

   assign w_tmr_zero = (r_tmr == '0);
   assign w_stop_ok  = (r_state == S_STOP) && w_tmr_zero && r_rxd;
   // Fullness uses the pre-pop count, so a simultaneous pop never makes room.
   assign w_full     = (r_count == c_depth);
   assign w_push     = w_stop_ok && !w_full;
   assign w_ovr_evt  = w_stop_ok && w_full;
   assign w_pop      = r_rvalid && rready_i;

   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop)
         w_count_nxt = r_count + 1'b1;
      else if (w_pop && !w_push)
         w_count_nxt = r_count - 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= S_IDLE;
         r_tmr       <= '0;
         r_bit_idx   <= '0;
         r_shift     <= '0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_frame_err <= 1'b0;
         if (w_ovr_evt)
            r_overrun <= 1'b1;
         else if (clr_i)
            r_overrun <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (!r_rxd) begin
                  r_state <= S_START;
                  r_tmr   <= c_half_wait;
               end
            end
            S_START: begin
               if (!w_tmr_zero) begin
                  r_tmr <= r_tmr - 1'b1;
               end else if (!r_rxd) begin
                  r_state   <= S_DATA;
                  r_tmr     <= c_full_wait;
                  r_bit_idx <= '0;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_DATA: begin
               if (!w_tmr_zero) begin
                  r_tmr <= r_tmr - 1'b1;
               end else begin
                  r_shift <= {r_rxd, r_shift[7:1]};
                  r_tmr   <= c_full_wait;
                  if (r_bit_idx == 3'd7)
                     r_state <= S_STOP;
                  else
                     r_bit_idx <= r_bit_idx + 1'b1;
               end
            end
            S_STOP: begin
               if (!w_tmr_zero) begin
                  r_tmr <= r_tmr - 1'b1;
               end else if (r_rxd) begin
                  r_state <= S_IDLE;
               end else begin
                  r_frame_err <= 1'b1;
                  r_state     <= S_BREAK;
               end
            end
            S_BREAK: begin
               if (r_rxd)
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < FIFO_DEPTH; i++)
            r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_rvalid <= 1'b0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= r_shift;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count  <= w_count_nxt;
         r_rvalid <= (w_count_nxt != '0);
      end
   end

   assign rvalid_o    = r_rvalid;
   assign rdata_o     = r_mem[r_rd_ptr];
   assign frame_err_o = r_frame_err;
   assign overrun_o   = r_overrun;
   assign count_o     = r_count;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_buffered.sv
// ============================================================================
// Module  : tb_uart_rx_buffered
// Brief   : Directed self-checking bench for uart_rx_buffered (WAIT_COUNT=10).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_buffered;

   localparam int CLK_FREQ_MHZ = 100;
   localparam int BAUD_RATE    = 10000000;
   localparam int FIFO_DEPTH   = 4;
   localparam int BIT_CYC      = 10;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic       rxd_i = 1'b1;
   logic       rvalid_o;
   logic       rready_i = 1'b0;
   logic [7:0] rdata_o;
   logic       frame_err_o;
   logic       overrun_o;
   logic       clr_i = 1'b0;
   logic [2:0] count_o;

   int checks   = 0;
   int failures = 0;

   int         fe_count  = 0;
   int         max_count = 0;
   logic       rec_en    = 1'b0;
   logic [7:0] rx_q[$];

   uart_rx_buffered #(
      .CLK_FREQ_MHZ (CLK_FREQ_MHZ),
      .BAUD_RATE    (BAUD_RATE),
      .FIFO_DEPTH   (FIFO_DEPTH)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .rxd_i       (rxd_i),
      .rvalid_o    (rvalid_o),
      .rready_i    (rready_i),
      .rdata_o     (rdata_o),
      .frame_err_o (frame_err_o),
      .overrun_o   (overrun_o),
      .clr_i       (clr_i),
      .count_o     (count_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) begin
      if (frame_err_o)
         fe_count <= fe_count + 1;
      if (rec_en && rvalid_o && rready_i)
         rx_q.push_back(rdata_o);
      if (rec_en && int'(count_o) > max_count)
         max_count <= int'(count_o);
   end

   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      rxd_i = 1'b0;
      repeat (BIT_CYC) @(negedge clk_i);
      for (int i = 0; i < 8; i++) begin
         rxd_i = b[i];
         repeat (BIT_CYC) @(negedge clk_i);
      end
      rxd_i = stop_bit;
      repeat (BIT_CYC) @(negedge clk_i);
      rxd_i = 1'b1;
   endtask

   task automatic pop_one();
      rready_i = 1'b1;
      @(negedge clk_i);
      rready_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      repeat (3) @(negedge clk_i);
      checks++;
      if (rvalid_o !== 1'b0 || rdata_o !== 8'h00 || count_o !== 3'd0 ||
          frame_err_o !== 1'b0 || overrun_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: got rvalid=%b rdata=%h count=%0d fe=%b ovr=%b, want 0/00/0/0/0",
                  rvalid_o, rdata_o, count_o, frame_err_o, overrun_o);
      end
      rst_ni = 1'b1;
      repeat (5) @(negedge clk_i);
   endtask

   task automatic test_single_frame();
      int fe0;
      fe0 = fe_count;
      send_frame(8'h55, 1'b1);
      repeat (3) @(negedge clk_i);
      checks++;
      if (rvalid_o !== 1'b1 || rdata_o !== 8'h55 || count_o !== 3'd1) begin
         failures++;
         $display("FAIL single_frame: got rvalid=%b rdata=%h count=%0d, want 1/55/1",
                  rvalid_o, rdata_o, count_o);
      end
      checks++;
      if (fe_count != fe0 || overrun_o !== 1'b0) begin
         failures++;
         $display("FAIL single_flags: got fe_pulses=%0d ovr=%b, want 0/0", fe_count - fe0, overrun_o);
      end
      pop_one();
      checks++;
      if (rvalid_o !== 1'b0 || count_o !== 3'd0) begin
         failures++;
         $display("FAIL single_pop: got rvalid=%b count=%0d, want 0/0", rvalid_o, count_o);
      end
   endtask

   task automatic test_false_start();
      int fe0;
      fe0 = fe_count;
      rxd_i = 1'b0;
      repeat (3) @(negedge clk_i);
      rxd_i = 1'b1;
      repeat (150) @(negedge clk_i);
      checks++;
      if (count_o !== 3'd0 || rvalid_o !== 1'b0 || fe_count != fe0 || overrun_o !== 1'b0) begin
         failures++;
         $display("FAIL false_start: got count=%0d rvalid=%b fe_pulses=%0d ovr=%b, want 0/0/0/0",
                  count_o, rvalid_o, fe_count - fe0, overrun_o);
      end
   endtask

   task automatic test_frame_error();
      int fe0;
      fe0 = fe_count;
      send_frame(8'hA3, 1'b0);
      rxd_i = 1'b0;
      repeat (30) @(negedge clk_i);
      rxd_i = 1'b1;
      repeat (20) @(negedge clk_i);
      checks++;
      if (fe_count - fe0 != 1 || count_o !== 3'd0) begin
         failures++;
         $display("FAIL frame_err_pulse: got pulses=%0d count=%0d, want 1/0", fe_count - fe0, count_o);
      end
      send_frame(8'h01, 1'b1);
      repeat (3) @(negedge clk_i);
      checks++;
      if (fe_count - fe0 != 1 || count_o !== 3'd1 || rdata_o !== 8'h01) begin
         failures++;
         $display("FAIL frame_err_recover: got pulses=%0d count=%0d rdata=%h, want 1/1/01",
                  fe_count - fe0, count_o, rdata_o);
      end
      pop_one();
   endtask

   task automatic test_overrun();
      logic [7:0] exp;
      for (int i = 0; i < 5; i++)
         send_frame(8'h10 + 8'(i), 1'b1);
      repeat (3) @(negedge clk_i);
      checks++;
      if (count_o !== 3'd4 || overrun_o !== 1'b1 || rvalid_o !== 1'b1) begin
         failures++;
         $display("FAIL overrun_full: got count=%0d ovr=%b rvalid=%b, want 4/1/1",
                  count_o, overrun_o, rvalid_o);
      end
      for (int i = 0; i < 4; i++) begin
         exp = 8'h10 + 8'(i);
         checks++;
         if (rdata_o !== exp || rvalid_o !== 1'b1) begin
            failures++;
            $display("FAIL overrun_pop%0d: got rdata=%h rvalid=%b, want %h/1", i, rdata_o, rvalid_o, exp);
         end
         pop_one();
      end
      checks++;
      if (count_o !== 3'd0 || rvalid_o !== 1'b0 || overrun_o !== 1'b1) begin
         failures++;
         $display("FAIL overrun_drained: got count=%0d rvalid=%b ovr=%b, want 0/0/1",
                  count_o, rvalid_o, overrun_o);
      end
      clr_i = 1'b1;
      @(negedge clk_i);
      clr_i = 1'b0;
      checks++;
      if (overrun_o !== 1'b0) begin
         failures++;
         $display("FAIL overrun_clear: got ovr=%b, want 0", overrun_o);
      end
   endtask

   task automatic test_back_to_back();
      rx_q.delete();
      max_count = 0;
      rready_i  = 1'b1;
      rec_en    = 1'b1;
      for (int i = 0; i < 8; i++)
         send_frame(8'(i), 1'b1);
      repeat (5) @(negedge clk_i);
      rec_en   = 1'b0;
      rready_i = 1'b0;
      checks++;
      if (rx_q.size() != 8) begin
         failures++;
         $display("FAIL b2b_count: got %0d bytes, want 8", rx_q.size());
      end
      for (int i = 0; i < 8; i++) begin
         if (i < rx_q.size()) begin
            checks++;
            if (rx_q[i] !== 8'(i)) begin
               failures++;
               $display("FAIL b2b_byte%0d: got %h, want %h", i, rx_q[i], 8'(i));
            end
         end
      end
      checks++;
      if (max_count > 1 || count_o !== 3'd0) begin
         failures++;
         $display("FAIL b2b_occupancy: got max=%0d final=%0d, want <=1/0", max_count, count_o);
      end
   endtask

   task automatic test_reset_mid_frame();
      send_frame(8'h99, 1'b1);
      repeat (3) @(negedge clk_i);
      checks++;
      if (count_o !== 3'd1 || rdata_o !== 8'h99) begin
         failures++;
         $display("FAIL pre_reset_fill: got count=%0d rdata=%h, want 1/99", count_o, rdata_o);
      end
      // 0xF0: start, bits 0..3 low, then half-way into bit 4 (high).
      rxd_i = 1'b0;
      repeat (5 * BIT_CYC) @(negedge clk_i);
      rxd_i = 1'b1;
      repeat (BIT_CYC / 2) @(negedge clk_i);
      #2 rst_ni = 1'b0;
      #1;
      checks++;
      if (rvalid_o !== 1'b0 || rdata_o !== 8'h00 || count_o !== 3'd0 ||
          frame_err_o !== 1'b0 || overrun_o !== 1'b0) begin
         failures++;
         $display("FAIL async_reset: got rvalid=%b rdata=%h count=%0d fe=%b ovr=%b, want 0/00/0/0/0",
                  rvalid_o, rdata_o, count_o, frame_err_o, overrun_o);
      end
      repeat (3) @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (3) @(negedge clk_i);
      send_frame(8'h3C, 1'b1);
      repeat (3) @(negedge clk_i);
      checks++;
      if (count_o !== 3'd1 || rvalid_o !== 1'b1 || rdata_o !== 8'h3C) begin
         failures++;
         $display("FAIL post_reset_frame: got count=%0d rvalid=%b rdata=%h, want 1/1/3C",
                  count_o, rvalid_o, rdata_o);
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_false_start();
      test_frame_error();
      test_overrun();
      test_back_to_back();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
